alu_reservation_station: RTL
============================

Name: alu_reservation_station

Overview:
- Receiving end of the infodecoder control interface for the ALU path.
- Accepts a decoded instruction when `stationRequest` is high and `RSstation` equals `STATION_ID`.
- Holds each instruction until both source operands are available, capturing operands from the common data bus (CDB), then issues one ready instruction per cycle to the ALU through a valid/ready handshake.
- Sits between rename/dispatch and the ALU functional unit.

Parameters:
- DEPTH, 4, number of entries (power of 2, ≥2).
- TAG_W, 4, ROB tag width.
- STATION_ID, 2'b00, `RSstation` code this station accepts.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high; clears all state on the rising edge of `clk`.
- stationRequest  in  1  instruction needs a station.
- RSstation  in  2  target station code.
- aluOp  in  2  ALU operation class.
- funct  in  4  ALU sub-operation.
- useImm  in  1  operand B is `immExt`.
- immExt  in  32  extended immediate.
- robTag  in  TAG_W  destination ROB tag.
- srcAVal, srcBVal  in  32  operand values when ready.
- srcARdy, srcBRdy  in  1  operand value is valid.
- srcATag, srcBTag  in  TAG_W  producing ROB tag when not ready.
- cdbValid  in  1  CDB broadcast valid.
- cdbTag  in  TAG_W  CDB producer tag.
- cdbValue  in  32  CDB result.
- flush  in  1  mispredict flush.
- issueReady  in  1  ALU accepts.
- full  out  1  no free entry.
- dispatchAck  out  1  dispatch accepted this cycle.
- issueValid  out  1  an entry is issuing.
- issueAluOp  out  2  issued `aluOp`.
- issueFunct  out  4  issued `funct`.
- issueA, issueB  out  32  issued operands.
- issueTag  out  TAG_W  issued ROB tag.

Behaviour:
- Reset: all entries invalid; `full`=0, `dispatchAck`=0, `issueValid`=0, and all issue data outputs are 0. Reset overrides `flush`, dispatch and issue.
- Entry contents: valid, aluOp, funct, tag, and for each of A/B: rdy, srcTag, val.
- Dispatch condition: `stationRequest` && `RSstation`==STATION_ID && !`full`.
  - `dispatchAck` is combinational, high in the same cycle.
  - The instruction is written at the next edge into the lowest-index free entry.
- Operand B with `useImm`=1: B.val=`immExt`, B.rdy=1; `srcB*` inputs are ignored.
- Dispatch-cycle forwarding: if an operand is not ready and `cdbValid` && `cdbTag`==its srcTag in the dispatch cycle, store `cdbValue` with rdy=1.
- Wakeup: every cycle, each valid entry with a non-ready operand whose srcTag==`cdbTag` (while `cdbValid`) captures `cdbValue` and sets rdy=1 at the next edge. A and B are matched independently, so both may capture in the same cycle.
- Ready: valid && A.rdy && B.rdy, evaluated on registered state. A CDB capture makes the entry issuable one cycle later, never in the same cycle.
- Select: lowest-index ready entry, unless the optional feature is enabled.
  - `issueValid` is combinational from registered state; `issue*` outputs carry the selected entry.
  - Outputs hold stable while `issueValid` && !`issueReady`, unless a higher-priority entry becomes ready (allowed; the ALU samples only on handshake).
- Free: on `issueValid` && `issueReady`, the selected entry's valid clears at the next edge.
- `full` is computed from registered valid bits only. A slot freed by issue is reusable starting the next cycle, so dispatch and issue in the same cycle while full is rejected.
- Flush: on `flush`=1, all valid bits clear at the next edge.
  - Any dispatch in that cycle is dropped and `dispatchAck`=0.
  - An issue handshake in that cycle is still presented, but its entry is cleared anyway.
- Simultaneous dispatch and issue, not full: both take effect and the count is unchanged.
- Tag 0 is a legal tag; readiness is tracked only by rdy bits.

Optional Feature:
- Macro: RS_OLDEST_FIRST_EN.
- Defined:
  - Each entry carries an age counter, width clog2(DEPTH), set to 0 on dispatch.
  - Every valid entry's age increments (saturating at DEPTH-1) on each accepted dispatch.
  - Select picks the ready entry with the largest age; ties go to the lower index.
- Undefined: no age state; select is lowest index.

Test Plan:
- Reset, then dispatch R-type: `robTag`=3, A ready 5, B ready 7 → `dispatchAck`=1; next cycle `issueValid`=1, issueA=5, issueB=7, issueTag=3; with `issueReady`=1 the entry is freed.
- Dispatch I-type: A not ready (srcATag=9), `useImm`=1, `immExt`=0xFFFFFFF0; hold 3 cycles → `issueValid`=0. Then CDB tag 9 value 0x10 → `issueValid`=1 the cycle after, issueA=0x10, issueB=0xFFFFFFF0.
- Dispatch with srcATag=6 while the CDB broadcasts tag 6 value 0x2A in the same cycle → operand captured; issue next cycle with issueA=0x2A.
- Fill DEPTH=4 entries, none ready → `full`=1 and a 5th request gets `dispatchAck`=0. Wake entry 2, issue it → `full`=0 the cycle after the handshake, and a new dispatch lands in entry 2.
- Two entries ready with `issueReady`=0 for 2 cycles → `issueValid` held with the same tag. Assert `flush` → all entries invalid and `issueValid`=0 next cycle.
- With RS_OLDEST_FIRST_EN: dispatch tag 1 into entry 0, tag 2 into entry 1, free entry 0, dispatch tag 3 into entry 0; make all ready → issue order is tags 2, 3. Without the macro the order is 3, 2.

Source files
------------

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched instructions until both operands arrive from
// the CDB, then issues one per cycle. Define RS_OLDEST_FIRST_EN for oldest-ready selection.
module alu_reservation_station #(
  parameter int         DEPTH      = 4,
  parameter int         TAG_W      = 4,
  parameter logic [1:0] STATION_ID = 2'b00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stationRequest,
  input  logic [1:0]       RSstation,
  input  logic [1:0]       aluOp,
  input  logic [3:0]       funct,
  input  logic             useImm,
  input  logic [31:0]      immExt,
  input  logic [TAG_W-1:0] robTag,
  input  logic [31:0]      srcAVal,
  input  logic [31:0]      srcBVal,
  input  logic             srcARdy,
  input  logic             srcBRdy,
  input  logic [TAG_W-1:0] srcATag,
  input  logic [TAG_W-1:0] srcBTag,
  input  logic             cdbValid,
  input  logic [TAG_W-1:0] cdbTag,
  input  logic [31:0]      cdbValue,
  input  logic             flush,
  input  logic             issueReady,
  output logic             full,
  output logic             dispatchAck,
  output logic             issueValid,
  output logic [1:0]       issueAluOp,
  output logic [3:0]       issueFunct,
  output logic [31:0]      issueA,
  output logic [31:0]      issueB,
  output logic [TAG_W-1:0] issueTag
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] a_rdy;
  logic [DEPTH-1:0] b_rdy;
  logic [1:0]       op    [DEPTH];
  logic [3:0]       fn    [DEPTH];
  logic [TAG_W-1:0] tag   [DEPTH];
  logic [TAG_W-1:0] a_tag [DEPTH];
  logic [TAG_W-1:0] b_tag [DEPTH];
  logic [31:0]      a_val [DEPTH];
  logic [31:0]      b_val [DEPTH];
`ifdef RS_OLDEST_FIRST_EN
  logic [IDX_W-1:0] age   [DEPTH];
  logic [IDX_W-1:0] best_age;
  logic             found;
`endif

  logic [DEPTH-1:0] ready;
  logic             handshake;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             in_a_rdy;
  logic             in_b_rdy;
  logic [31:0]      in_a_val;
  logic [31:0]      in_b_val;

  assign ready       = valid & a_rdy & b_rdy;
  assign full        = &valid;
  assign dispatchAck = !reset && !flush && stationRequest && (RSstation == STATION_ID) && !full;
  assign issueValid  = !reset && (|ready);
  assign handshake   = issueValid && issueReady;

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!valid[i]) free_idx = IDX_W'(i);
  end

  // Strict greater-than keeps ties on the lower index.
  always_comb begin
    sel_idx = '0;
`ifdef RS_OLDEST_FIRST_EN
    best_age = '0;
    found    = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (ready[i] && (!found || age[i] > best_age)) begin
        found    = 1'b1;
        best_age = age[i];
        sel_idx  = IDX_W'(i);
      end
`else
    for (int i = DEPTH - 1; i >= 0; i--)
      if (ready[i]) sel_idx = IDX_W'(i);
`endif
  end

  // Operands presented at dispatch, with same-cycle CDB forwarding.
  always_comb begin
    in_a_rdy = srcARdy;
    in_a_val = srcAVal;
    if (!srcARdy && cdbValid && (cdbTag == srcATag)) begin
      in_a_rdy = 1'b1;
      in_a_val = cdbValue;
    end
    in_b_rdy = srcBRdy;
    in_b_val = srcBVal;
    if (useImm) begin
      in_b_rdy = 1'b1;
      in_b_val = immExt;
    end else if (!srcBRdy && cdbValid && (cdbTag == srcBTag)) begin
      in_b_rdy = 1'b1;
      in_b_val = cdbValue;
    end
  end

  assign issueAluOp = issueValid ? op[sel_idx]    : '0;
  assign issueFunct = issueValid ? fn[sel_idx]    : '0;
  assign issueA     = issueValid ? a_val[sel_idx] : '0;
  assign issueB     = issueValid ? b_val[sel_idx] : '0;
  assign issueTag   = issueValid ? tag[sel_idx]   : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
      a_rdy <= '0;
      b_rdy <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op[i]    <= '0;
        fn[i]    <= '0;
        tag[i]   <= '0;
        a_tag[i] <= '0;
        b_tag[i] <= '0;
        a_val[i] <= '0;
        b_val[i] <= '0;
`ifdef RS_OLDEST_FIRST_EN
        age[i]   <= '0;
`endif
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid[i] && !a_rdy[i] && cdbValid && (cdbTag == a_tag[i])) begin
          a_rdy[i] <= 1'b1;
          a_val[i] <= cdbValue;
        end
        if (valid[i] && !b_rdy[i] && cdbValid && (cdbTag == b_tag[i])) begin
          b_rdy[i] <= 1'b1;
          b_val[i] <= cdbValue;
        end
`ifdef RS_OLDEST_FIRST_EN
        if (dispatchAck && valid[i] && (age[i] != IDX_W'(DEPTH - 1)))
          age[i] <= age[i] + IDX_W'(1);
`endif
      end
      if (handshake)
        valid[sel_idx] <= 1'b0;
      // free_idx is never the issuing entry, so dispatch and issue cannot collide.
      if (dispatchAck) begin
        valid[free_idx] <= 1'b1;
        op[free_idx]    <= aluOp;
        fn[free_idx]    <= funct;
        tag[free_idx]   <= robTag;
        a_rdy[free_idx] <= in_a_rdy;
        a_val[free_idx] <= in_a_val;
        a_tag[free_idx] <= srcATag;
        b_rdy[free_idx] <= in_b_rdy;
        b_val[free_idx] <= in_b_val;
        b_tag[free_idx] <= srcBTag;
`ifdef RS_OLDEST_FIRST_EN
        age[free_idx]   <= '0;
`endif
      end
      if (flush)
        valid <= '0;
    end
  end

endmodule
